// File: rtl/seg_pkg.sv
// seg_pkg: segment constants, hex glyph table and the frame
// snapshot bundle shared by the seven-segment scanner.
package seg_pkg;

  // Active-low segment codes, bit7 = DP, bits6:0 = g..a.
  localparam logic [7:0] SEG_DIM  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;

  // Entry k is the glyph for hex digit k (0 at the low end).
  localparam logic [15:0][7:0] HEX_TAB = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic        bad;
    logic        lz;
    logic [3:0]  digits;
    logic [31:0] data;
  } snap_t;

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex digit to active-low g..a segments.
// Ports: hex_i (4-bit digit), seg_o (7-bit segments, active-low).
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_TAB[hex_i][6:0];

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed 7-seg scanner with per-frame source
// snapshot, leading-zero suppression, live DP mask and anode blanking.
// Ports: clk, rst (sync, high); src_data/src_digits/sel/lz_suppress
// (snapshotted per frame); dp_mask (live); an_n, seg_n, frame_start.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int NUM_SRC    = 8,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 16,
  localparam int SELW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC*32-1:0]   src_data,
  input  logic [NUM_SRC*4-1:0]    src_digits,
  input  logic [SELW-1:0]         sel,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [7:0]              seg_n,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [3:0]    ND4      = 4'(NUM_DIGITS);

  logic [PW-1:0]         pre_q;
  logic [IW-1:0]         idx_q;
  snap_t                 snap_q;
  snap_t                 snap_d;
  logic                  fs_q;
  logic                  first_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]            seg_q;
  logic [7:0]            seg_d;

  logic       tick;
  logic       frame_b;
  logic [3:0] nib;
  logic [6:0] hex_seg;
  logic [3:0] n_eff;
  logic       upper_zero;
  logic       dp_off;

  assign tick    = (pre_q == PRE_LAST);
  // first_q marks the first cycle after reset release
  assign frame_b = (tick && idx_q == IDX_LAST) || first_q;

  always_comb begin
    snap_d        = '0;
    snap_d.lz     = lz_suppress;
    snap_d.bad    = {1'b0, sel} >= (SELW + 1)'(NUM_SRC);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SELW'(k)) begin
        snap_d.data   = src_data[32*k +: 32];
        snap_d.digits = src_digits[4*k +: 4];
      end
    end
  end

  assign nib = snap_q.data[{idx_q, 2'b00} +: 4];

  hex7seg u_hex (
    .hex_i (nib),
    .seg_o (hex_seg)
  );

  always_comb begin
    n_eff = (snap_q.digits == 4'd0 || snap_q.digits > ND4)
          ? ND4 : snap_q.digits;
    // all nibbles from the current digit up to N-1 are zero
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_q) && j < int'(n_eff)
          && snap_q.data[4*j +: 4] != 4'd0)
        upper_zero = 1'b0;
    end
    dp_off = ~dp_mask[idx_q];
    if (snap_q.bad)
      seg_d = {dp_off, SEG_DASH[6:0]};
    else if (4'(idx_q) >= n_eff)
      seg_d = SEG_DIM;
    else if (snap_q.lz && idx_q != '0 && upper_zero)
      seg_d = {dp_off, SEG_DIM[6:0]};
    else
      seg_d = {dp_off, hex_seg};
  end

  always_comb begin
    an_d = '1;
    if (int'(pre_q) >= BLANK_CYC)
      an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      fs_q    <= 1'b0;
      first_q <= 1'b1;
      an_q    <= '1;
      seg_q   <= SEG_DIM;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick)
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      if (frame_b)
        snap_q <= snap_d;
      fs_q    <= frame_b;
      first_q <= 1'b0;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an_n        = an_q;
  assign seg_n       = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: random and directed scenarios checked against
// a cycle-count reference model of the scanner.
`timescale 1ns/1ps
module tb_seg_scan_display;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int ND    = 8;
  localparam int NS    = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NS*32-1:0] src_data = '0;
  logic [NS*4-1:0]  src_digits = '0;
  logic [2:0]      sel = '0;
  logic            lz = 1'b0;
  logic [7:0]      dp_mask = '0;
  logic [7:0]      an_n;
  logic [7:0]      seg_n;
  logic            frame_start;

  logic [5*32-1:0] src_data5 = '0;
  logic [19:0]     src_digits5 = '0;
  logic [2:0]      sel5 = 3'd6;
  logic            lz5 = 1'b0;
  logic [7:0]      dp5 = '0;
  logic [7:0]      an5;
  logic [7:0]      seg5;
  logic            fs5;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_an;
  logic [7:0] exp_seg;
  logic       exp_fs;
  int         m_idx;
  int         cyc;
  logic [31:0] s_word;
  int         s_dig;
  bit         s_lz;
  int         s_sel;

  logic [7:0] seen [8];
  int         lowcnt [8];

  logic [7:0] hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  always #5 clk = ~clk;

  seg_scan_display #(
    .NUM_DIGITS(ND), .NUM_SRC(NS), .DIV(DIV), .BLANK_CYC(BLANK)
  ) u_dut (
    .clk(clk), .rst(rst), .src_data(src_data),
    .src_digits(src_digits), .sel(sel), .lz_suppress(lz),
    .dp_mask(dp_mask), .an_n(an_n), .seg_n(seg_n),
    .frame_start(frame_start)
  );

  seg_scan_display #(
    .NUM_DIGITS(ND), .NUM_SRC(5), .DIV(DIV), .BLANK_CYC(BLANK)
  ) u_dut5 (
    .clk(clk), .rst(rst), .src_data(src_data5),
    .src_digits(src_digits5), .sel(sel5), .lz_suppress(lz5),
    .dp_mask(dp5), .an_n(an5), .seg_n(seg5),
    .frame_start(fs5)
  );

  function automatic logic [7:0] ref_seg(
    input logic [31:0] w, input int nd, input bit lz_on,
    input int s, input int nsrc, input int i, input logic [7:0] dp);
    int n;
    int nibv;
    logic [63:0] upper;
    logic dpo;
    logic [7:0] g;
    n = (nd == 0 || nd > ND) ? ND : nd;
    dpo = ~dp[i];
    if (s >= nsrc) return {dpo, 7'h3F};
    if (i >= n) return 8'hFF;
    upper = 64'(w) >> (4 * i);
    upper = upper % (64'd1 << (4 * (n - i)));
    if (lz_on && i > 0 && upper == 64'd0) return {dpo, 7'h7F};
    nibv = int'((w >> (4 * i)) & 32'hF);
    g = hex_tab[nibv];
    return {dpo, g[6:0]};
  endfunction

  function automatic int lit_digit(input logic [7:0] a);
    int r = -1;
    int c = 0;
    for (int i = 0; i < 8; i++)
      if (a[i] === 1'b0) begin r = i; c++; end
    return (c == 1) ? r : -1;
  endfunction

  // Model: cycle k after release is step k/DIV, phase k%DIV.
  always @(posedge clk) begin
    int p;
    int ix;
    bit bnd;
    if (rst) begin
      cyc = 0; s_word = '0; s_dig = 0; s_lz = 0; s_sel = 0;
      exp_an = 8'hFF; exp_seg = 8'hFF; exp_fs = 1'b0; m_idx = 0;
    end else begin
      p  = cyc % DIV;
      ix = (cyc / DIV) % ND;
      bnd = (cyc == 0) || (p == DIV - 1 && ix == ND - 1);
      exp_an  = (p < BLANK) ? 8'hFF : ~(8'b1 << ix);
      exp_seg = ref_seg(s_word, s_dig, s_lz, s_sel, NS, ix, dp_mask);
      exp_fs  = bnd;
      m_idx   = ix;
      if (bnd) begin
        s_sel  = int'(sel);
        s_word = src_data[32*sel +: 32];
        s_dig  = int'(src_digits[4*sel +: 4]);
        s_lz   = lz;
      end
      cyc++;
    end
  end

  task automatic test_reset();
    src_data[31:0]  = 32'h1234ABCD;
    src_digits[3:0] = 4'd0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (an_n !== 8'hFF) begin
        n_fail++; $display("FAIL reset an_n: got %h want ff", an_n);
      end
      n_checks++;
      if (seg_n !== 8'hFF) begin
        n_fail++; $display("FAIL reset seg_n: got %h want ff", seg_n);
      end
      n_checks++;
      if (frame_start !== 1'b0) begin
        n_fail++; $display("FAIL reset fs: got %b want 0", frame_start);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_hex_scan();
    logic [7:0] want [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88,
                             8'h99, 8'hB0, 8'hA4, 8'hF9};
    int d;
    for (int i = 0; i < 8; i++) begin seen[i] = 'x; lowcnt[i] = 0; end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n_checks++;
      if (an_n !== exp_an) begin
        n_fail++; $display("FAIL hex an_n: got %h want %h", an_n, exp_an);
      end
      n_checks++;
      if (seg_n !== exp_seg) begin
        n_fail++; $display("FAIL hex seg_n: got %h want %h", seg_n, exp_seg);
      end
      n_checks++;
      if (frame_start !== exp_fs) begin
        n_fail++; $display("FAIL hex fs: got %b want %b", frame_start, exp_fs);
      end
      if (k == 0) begin
        n_checks++;
        if (frame_start !== 1'b1) begin
          n_fail++; $display("FAIL hex first_fs: got %b want 1", frame_start);
        end
      end
      d = lit_digit(an_n);
      if (d >= 0 && k < 32) begin seen[d] = seg_n; lowcnt[d]++; end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (seen[i] !== want[i]) begin
        n_fail++; $display("FAIL hex digit%0d: got %h want %h", i, seen[i], want[i]);
      end
      n_checks++;
      if (lowcnt[i] != DIV - BLANK) begin
        n_fail++; $display("FAIL hex lowcnt%0d: got %0d want %0d", i, lowcnt[i], DIV - BLANK);
      end
    end
  endtask

  task automatic test_lz();
    int d;
    for (int pass = 0; pass < 2; pass++) begin
      src_data[31:0]  = 32'h0000_00A5;
      src_digits[3:0] = 4'd8;
      lz = (pass == 0);
      for (int i = 0; i < 8; i++) seen[i] = 'x;
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        n_checks++;
        if (an_n !== exp_an) begin
          n_fail++; $display("FAIL lz an_n: got %h want %h", an_n, exp_an);
        end
        n_checks++;
        if (seg_n !== exp_seg) begin
          n_fail++; $display("FAIL lz seg_n: got %h want %h", seg_n, exp_seg);
        end
        d = lit_digit(an_n);
        if (d >= 0 && k >= 32) seen[d] = seg_n;
      end
      n_checks++;
      if (seen[0] !== 8'h92 || seen[1] !== 8'h88) begin
        n_fail++; $display("FAIL lz low: got %h %h want 92 88", seen[0], seen[1]);
      end
      for (int i = 2; i < 8; i++) begin
        n_checks++;
        if (seen[i] !== (pass == 0 ? 8'hFF : 8'hC0)) begin
          n_fail++; $display("FAIL lz digit%0d pass%0d: got %h", i, pass, seen[i]);
        end
      end
    end
    lz = 1'b0;
  endtask

  task automatic test_digits_dp();
    int d;
    src_data[31:0]  = 32'hFFFF1234;
    src_digits[3:0] = 4'd4;
    dp_mask = 8'hFF;
    for (int i = 0; i < 8; i++) seen[i] = 'x;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n_checks++;
      if (an_n !== exp_an) begin
        n_fail++; $display("FAIL ndig an_n: got %h want %h", an_n, exp_an);
      end
      n_checks++;
      if (seg_n !== exp_seg) begin
        n_fail++; $display("FAIL ndig seg_n: got %h want %h", seg_n, exp_seg);
      end
      d = lit_digit(an_n);
      if (d >= 0 && k >= 32) seen[d] = seg_n;
    end
    n_checks++;
    if (seen[0] !== 8'h19) begin
      n_fail++; $display("FAIL ndig digit0: got %h want 19", seen[0]);
    end
    for (int i = 4; i < 8; i++) begin
      n_checks++;
      if (seen[i] !== 8'hFF) begin
        n_fail++; $display("FAIL ndig digit%0d: got %h want ff", i, seen[i]);
      end
    end
    dp_mask = 8'h00;
    src_digits[3:0] = 4'd0;
  endtask

  task automatic test_no_tearing();
    logic [31:0] w0 = 32'h7654_3210;
    logic [31:0] w1 = 32'hFEDC_BA98;
    int d;
    int guard;
    bit got;
    src_data[31:0]  = w0;
    src_data[63:32] = w1;
    src_digits[7:0] = 8'h00;
    sel = 3'd0;
    repeat (40) @(negedge clk);
    guard = 0;
    while (m_idx != 3 && guard < 40) begin @(negedge clk); guard++; end
    n_checks++;
    if (m_idx != 3) begin
      n_fail++; $display("FAIL tear idx3: got %0d want 3", m_idx);
    end
    sel = 3'd1;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      n_checks++;
      if (seg_n !== exp_seg) begin
        n_fail++; $display("FAIL tear seg_n: got %h want %h", seg_n, exp_seg);
      end
      d = lit_digit(an_n);
      if (d >= 0) begin
        n_checks++;
        if (seg_n !== ref_seg(w0, 0, 0, 0, NS, d, 8'h00)) begin
          n_fail++; $display("FAIL tear old digit%0d: got %h", d, seg_n);
        end
      end
      got = (frame_start === 1'b1);
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL tear fs: got 0 want 1 within 40 cycles");
    end
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d = lit_digit(an_n);
      if (d >= 0) begin
        n_checks++;
        if (seg_n !== ref_seg(w1, 0, 0, 1, NS, d, 8'h00)) begin
          n_fail++; $display("FAIL tear new digit%0d: got %h", d, seg_n);
        end
      end
    end
    sel = 3'd0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < NS; s++) begin
        src_data[32*s +: 32]  = $urandom >> (4 * $urandom_range(0, 8));
        src_digits[4*s +: 4]  = 4'($urandom_range(0, 15));
      end
      sel = 3'($urandom_range(0, 7));
      lz  = 1'($urandom_range(0, 1));
      for (int k = 0; k < 48; k++) begin
        dp_mask = 8'($urandom);
        @(negedge clk);
        n_checks++;
        if (an_n !== exp_an) begin
          n_fail++; $display("FAIL rand an_n: got %h want %h", an_n, exp_an);
        end
        n_checks++;
        if (seg_n !== exp_seg) begin
          n_fail++; $display("FAIL rand seg_n: got %h want %h", seg_n, exp_seg);
        end
        n_checks++;
        if (frame_start !== exp_fs) begin
          n_fail++; $display("FAIL rand fs: got %b want %b", frame_start, exp_fs);
        end
      end
    end
    dp_mask = 8'h00;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (m_idx != 5 && guard < 40) begin @(negedge clk); guard++; end
    n_checks++;
    if (m_idx != 5) begin
      n_fail++; $display("FAIL rstmid idx5: got %0d want 5", m_idx);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (an_n !== 8'hFF || seg_n !== 8'hFF || frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid hold: got %h %h %b want ff ff 0", an_n, seg_n, frame_start);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (an_n !== exp_an || seg_n !== exp_seg || frame_start !== exp_fs) begin
        n_fail++;
        $display("FAIL rstmid run: got %h %h %b want %h %h %b",
                 an_n, seg_n, frame_start, exp_an, exp_seg, exp_fs);
      end
      if (k == 0) begin
        n_checks++;
        if (frame_start !== 1'b1) begin
          n_fail++; $display("FAIL rstmid fs: got %b want 1", frame_start);
        end
      end
      if (k == 1) begin
        n_checks++;
        if (an_n !== 8'hFE) begin
          n_fail++; $display("FAIL rstmid idx0: got %h want fe", an_n);
        end
      end
    end
  endtask

  task automatic test_bad_sel();
    int d;
    int lit = 0;
    logic [7:0] w;
    for (int pass = 0; pass < 2; pass++) begin
      dp5 = (pass == 0) ? 8'h00 : 8'h05;
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        d = lit_digit(an5);
        if (d >= 0) begin
          lit++;
          w = dp5;
          n_checks++;
          if (seg5 !== {~w[d], 7'h3F}) begin
            n_fail++; $display("FAIL badsel digit%0d: got %h want %h", d, seg5, {~w[d], 7'h3F});
          end
        end
      end
    end
    n_checks++;
    if (lit == 0) begin
      n_fail++; $display("FAIL badsel lit: got 0 want >0");
    end
  endtask

  initial begin
    test_reset();
    test_hex_scan();
    test_lz();
    test_digits_dp();
    test_no_tearing();
    test_random();
    test_reset_mid();
    test_bad_sel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits, legal 1..8.
REQ-002 Parameter NUM_SRC, default 8, number of 32-bit display sources, legal 1..16.
REQ-003 Parameter DIV, default 50000, clk cycles per scan step, legal >= 2.
REQ-004 Parameter BLANK_CYC, default 16, anode-off cycles at the start of each scan step, legal 0..DIV-1.
REQ-005 clk  in  1  single clock, all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 src_data  in  NUM_SRC*32  flattened sources; source k occupies bits [32k+31:32k].
REQ-008 src_digits  in  NUM_SRC*4  valid-digit count per source, same packing at 4 bits per source.
REQ-009 sel  in  max(1,clog2(NUM_SRC))  source select.
REQ-010 lz_suppress  in  1  leading-zero suppression enable.
REQ-011 dp_mask  in  NUM_DIGITS  decimal point on for digit i when bit i = 1.
REQ-012 an_n  out  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-013 seg_n  out  8  segments, active-low, bit7 = DP, bits6:0 = g..a.
REQ-014 frame_start  out  1  one-cycle pulse when a new snapshot is taken.

Function
REQ-015 Prescaler counts 0..DIV-1 and wraps; a scan tick occurs in the cycle it equals DIV-1.
REQ-016 Scan index advances on each tick, 0..NUM_DIGITS-1, and wraps NUM_DIGITS-1 -> 0.
REQ-017 A frame boundary is a tick that wraps the index to 0, or the first cycle after rst deasserts.
REQ-018 At a frame boundary, sel, the selected src_data word, its src_digits and lz_suppress are latched into a snapshot; changes between boundaries have no visible effect (no tearing).
REQ-019 frame_start is 1 in exactly the cycle after each snapshot load, else 0.
REQ-020 Effective count N = snapshot src_digits, or NUM_DIGITS when that value is 0 or > NUM_DIGITS.
REQ-021 Digit i displays nibble [4i+3:4i] of the snapshot, hex-decoded (0-9, A, b, C, d, E, F).
REQ-022 Digits i >= N show 8'hFF (dim) and ignore dp_mask.
REQ-023 With lz_suppress latched = 1, digit i (1 <= i < N) shows 8'hFF with DP still applied when all nibbles i..N-1 are zero; digit 0 is never suppressed.
REQ-024 A latched sel >= NUM_SRC shows 8'hBF (dash) on every digit, DP applied.
REQ-025 seg_n[7] = ~dp_mask[i] for displayed digits; dp_mask is sampled live, not snapshotted.
REQ-026 an_n and seg_n are registered, valid 1 cycle after the index changes.
REQ-027 For the first BLANK_CYC cycles of each scan step an_n is all ones; after that an_n has only bit i low.
REQ-028 The prescaler and index keep running through snapshot loads; nothing stalls.

Reset
REQ-029 While rst = 1: prescaler 0, index 0, snapshot 0, an_n all ones, seg_n 8'hFF, frame_start 0.
REQ-030 rst asserted mid-frame aborts the frame; the first cycle after release is a frame boundary (REQ-017).

Structure
REQ-031 Shared package seg_pkg holds segment constants SEG_DIM = 8'hFF, SEG_DASH = 8'hBF and the 16-entry hex table (0 = 8'hC0 ... F = 8'h8E).
REQ-032 Sub-module hex7seg: 4-bit in, 7-bit active-low segments out, combinational, instantiated once.
REQ-033 Prescaler, index, snapshot and blanking logic live in seg_scan_display; no other sub-modules.

Verification (DIV=4, BLANK_CYC=1, NUM_DIGITS=8, NUM_SRC=8 unless noted)
REQ-034 sel=0, src0=32'h1234ABCD, digits=0, lz=0 -> digit0..7 seg_n = C6?no: D=8'hA1, C=8'hC6, B=8'h83, A=8'h88, 4=8'h99, 3=8'hB0, 2=8'hA4, 1=8'hF9; each an_n low for 3 of 4 cycles.
REQ-035 src0=32'h0000_00A5, lz=1, digits=8 -> digit0=8'h92, digit1=8'h88, digits2..7=8'hFF; with lz=0, digits2..7=8'hC0.
REQ-036 src_digits[0]=4, src0=32'hFFFF1234, dp_mask=8'hFF -> digits4..7=8'hFF, digit0=8'h19 (4 with DP).
REQ-037 Change sel 0->1 at index 3 -> digits 3..7 still show source 0; frame_start pulses after the wrap; the next frame shows source 1.
REQ-038 NUM_SRC=5, sel=6 -> all digits 8'hBF.
REQ-039 Assert rst at index 5 for 2 cycles -> an_n all ones, seg_n 8'hFF; after release frame_start pulses, index restarts at 0.
